// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the MIPS instruction-fetch stage: NOP encoding, FSM state
// encodings, default reset PC and the instruction/PC+4 word carried through the stage.
package if_fetch_unit_pkg;

  localparam logic [31:0] NOP_INS          = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc4;
  } fetch_word_t;

  localparam fetch_word_t EMPTY_WORD = '{ins: NOP_INS, pc4: 32'h0000_0000};

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_skid_reg.sv
// One-entry holding register for an instruction word (and its PC+4) that returns
// from the ROM while the IF/ID register is frozen. Clear wins over load over unload.
module if_skid_reg
  import if_fetch_unit_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic        i_unload,
  input  fetch_word_t i_word,
  output logic        o_valid,
  output fetch_word_t o_word
);

  logic        r_valid;
  fetch_word_t r_word;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_valid <= 1'b0;
      r_word  <= EMPTY_WORD;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_word  <= i_word;
    end else if (i_unload) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_word  = r_word;

endmodule

// File: rtl/if_fetch_unit.sv
// MIPS IF stage: PC, synchronous ROM request, IF/ID register with stall skid and redirect flush.
// Optional macro IF_ALIGN_CHECK_EN: misaligned redirect halts the stage and raises sticky AlignErr.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          IMEM_AW  = 10
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               Stall,
  input  logic               Redirect,
  input  logic [31:0]        RedirectPC,
  output logic               ImemReq,
  output logic [IMEM_AW-1:0] ImemAddr,
  input  logic [31:0]        ImemData,
  output logic [31:0]        Ins,
  output logic [31:0]        InsPC4,
  output logic               InsValid
`ifdef IF_ALIGN_CHECK_EN
  ,
  output logic               AlignErr
`endif
);

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic        r_inflight;
  logic [31:0] r_inflight_pc4;
  fetch_word_t r_ifid;
  logic        r_ifid_valid;

  logic [1:0]  w_state_next;
  logic [31:0] w_pc_next;
  logic        w_req;
  logic        w_skid_load;
  logic        w_skid_clear;
  logic        w_skid_unload;
  logic        w_skid_valid;
  fetch_word_t w_skid_word;
  logic        w_ifid_load;
  logic        w_ifid_clear;
  fetch_word_t w_ifid_word;
  fetch_word_t w_imem_word;
  logic [31:0] w_target;
  logic        w_misaligned;

  assign w_target    = {RedirectPC[31:2], 2'b00};
  assign w_imem_word = '{ins: ImemData, pc4: r_inflight_pc4};

`ifdef IF_ALIGN_CHECK_EN
  logic r_align_err;

  assign w_misaligned = |RedirectPC[1:0];
  assign AlignErr     = r_align_err;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_align_err <= 1'b0;
    end else if (w_state_next == S_HALT) begin
      r_align_err <= 1'b1;
    end
  end
`else
  logic w_unused_low_bits;

  // Byte offset of the target is simply dropped in this build.
  assign w_unused_low_bits = ^RedirectPC[1:0];
  assign w_misaligned      = 1'b0;
`endif

  // Priority: halt > redirect (flush beats stall) > boot > stall > normal fetch.
  always_comb begin
    w_state_next  = r_state;
    w_pc_next     = r_pc;
    w_req         = 1'b0;
    w_skid_load   = 1'b0;
    w_skid_clear  = 1'b0;
    w_skid_unload = 1'b0;
    w_ifid_load   = 1'b0;
    w_ifid_clear  = 1'b0;
    w_ifid_word   = w_imem_word;
    if (r_state == S_HALT) begin
      w_ifid_clear = 1'b1;
      w_skid_clear = 1'b1;
    end else if (Redirect) begin
      w_ifid_clear = 1'b1;
      w_skid_clear = 1'b1;
      if (w_misaligned) begin
        w_state_next = S_HALT;
      end else begin
        w_state_next = S_RUN;
        w_pc_next    = w_target;
      end
    end else if (r_state != S_RUN) begin
      w_state_next = S_RUN;
    end else if (Stall) begin
      w_skid_load = r_inflight;
    end else begin
      w_req     = 1'b1;
      w_pc_next = pc_plus4(r_pc);
      // A word parked during the stall is older than anything still in flight.
      if (w_skid_valid) begin
        w_ifid_load   = 1'b1;
        w_ifid_word   = w_skid_word;
        w_skid_unload = 1'b1;
      end else if (r_inflight) begin
        w_ifid_load = 1'b1;
      end else begin
        w_ifid_clear = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state        <= S_BOOT;
      r_pc           <= RESET_PC;
      r_inflight     <= 1'b0;
      r_inflight_pc4 <= 32'h0000_0000;
      r_ifid         <= EMPTY_WORD;
      r_ifid_valid   <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_pc           <= w_pc_next;
      r_inflight     <= w_req;
      r_inflight_pc4 <= pc_plus4(r_pc);
      if (w_ifid_clear) begin
        r_ifid       <= EMPTY_WORD;
        r_ifid_valid <= 1'b0;
      end else if (w_ifid_load) begin
        r_ifid       <= w_ifid_word;
        r_ifid_valid <= 1'b1;
      end
    end
  end

  if_skid_reg u_skid (
    .i_clk    (CLK),
    .i_rst    (RST),
    .i_load   (w_skid_load),
    .i_clear  (w_skid_clear),
    .i_unload (w_skid_unload),
    .i_word   (w_imem_word),
    .o_valid  (w_skid_valid),
    .o_word   (w_skid_word)
  );

  assign ImemReq  = w_req & ~RST;
  assign ImemAddr = r_pc[IMEM_AW+1:2];
  assign Ins      = r_ifid.ins;
  assign InsPC4   = r_ifid.pc4;
  assign InsValid = r_ifid_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: stimulus predicts the instruction stream ID must see,
// a negedge monitor pops and compares every instruction ID consumes.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          AW       = 10;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          Stall = 1'b0;
  logic          Redirect = 1'b0;
  logic [31:0]   RedirectPC = 32'h0;
  logic          ImemReq;
  logic [AW-1:0] ImemAddr;
  logic [31:0]   ImemData = 32'h0;
  logic [31:0]   Ins;
  logic [31:0]   InsPC4;
  logic          InsValid;
`ifdef IF_ALIGN_CHECK_EN
  logic          AlignErr;
`endif

  always #5 CLK = ~CLK;

  if_fetch_unit #(.RESET_PC(RESET_PC), .IMEM_AW(AW)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .Stall      (Stall),
    .Redirect   (Redirect),
    .RedirectPC (RedirectPC),
    .ImemReq    (ImemReq),
    .ImemAddr   (ImemAddr),
    .ImemData   (ImemData),
    .Ins        (Ins),
    .InsPC4     (InsPC4),
    .InsValid   (InsValid)
`ifdef IF_ALIGN_CHECK_EN
    ,
    .AlignErr   (AlignErr)
`endif
  );

  // ROM model: one-cycle read latency, garbage on the bus when not requested.
  logic [31:0] rom [0:1023];
  always @(posedge CLK) ImemData <= ImemReq ? rom[ImemAddr] : $urandom;

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc4;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_next_pc = RESET_PC;
  int          n_checks = 0;
  int          n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h at t=%0t", name, act, req, $time);
  endtask

  // Keep a few upcoming sequential instructions queued from the current stream start.
  task automatic topup();
    while (exp_q.size() < 4) begin
      exp_t e;
      e.ins = rom[int'((m_next_pc >> 2) % 1024)];
      e.pc4 = m_next_pc + 32'd4;
      exp_q.push_back(e);
      m_next_pc = m_next_pc + 32'd4;
    end
  endtask

  task automatic step(input bit rst, input bit stall, input bit redir, input logic [31:0] tgt);
    @(posedge CLK);
    #1;
    topup();
    RST        = rst;
    Stall      = stall;
    Redirect   = redir;
    RedirectPC = tgt;
    if (rst) m_next_pc = RESET_PC;
    else if (redir) m_next_pc = tgt & 32'hFFFF_FFFC;
    $display("cycle rst=%0b stall=%0b redirect=%0b target=%h", rst, stall, redir, tgt);
  endtask

  function automatic logic [31:0] pick_target();
    logic [31:0] t;
    case ($urandom_range(0, 3))
      0:       t = 32'($urandom_range(0, 63)) << 2;
      1:       t = 32'h0000_0FF0 + (32'($urandom_range(0, 7)) << 2);
      2:       t = 32'hFFFF_FFF0 + (32'($urandom_range(0, 3)) << 2);
      default: t = $urandom;
    endcase
`ifdef IF_ALIGN_CHECK_EN
    t = t & 32'hFFFF_FFFC;
`else
    if ($urandom_range(0, 3) == 0) t = t | 32'($urandom_range(0, 3));
`endif
    return t;
  endfunction

  int since = 0;
  bit clean1 = 1'b0;
  bit clean2 = 1'b0;
  bit flush_prev = 1'b0;
  bit halted = 1'b0;

  always @(negedge CLK) begin
    exp_t e;
    bit   exp_req;
    if (RST) since = 0;
    else if (since < 1000) since++;
    exp_req = !RST && since >= 2 && !Stall && !Redirect && !halted;
    check("imem_req", 32'(ImemReq), 32'(exp_req));
    if (!InsValid) check("nop_when_invalid", Ins, 32'h0);
    if (flush_prev) check("invalid_after_flush", 32'(InsValid), 32'h0);
    if (halted) check("invalid_when_halted", 32'(InsValid), 32'h0);
    if (!halted && since >= 4 && clean1 && clean2) check("full_rate_valid", 32'(InsValid), 32'h1);
`ifdef IF_ALIGN_CHECK_EN
    check("align_err", 32'(AlignErr), 32'(halted));
`endif
    if (!RST && InsValid && (!Stall || Redirect)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_ins: got %h pc4 %h expected none", Ins, InsPC4);
      end else begin
        e = exp_q.pop_front();
        check("ins", Ins, e.ins);
        check("ins_pc4", InsPC4, e.pc4);
      end
    end
    if (RST || Redirect) exp_q.delete();
`ifdef IF_ALIGN_CHECK_EN
    if (RST) halted = 1'b0;
    else if (Redirect && RedirectPC[1:0] != 2'b00) halted = 1'b1;
`endif
    flush_prev = RST || Redirect;
    clean2     = clean1;
    clean1     = !RST && !Stall && !Redirect;
  end

  initial begin
    bit          r_rst;
    bit          r_stall;
    bit          r_redir;
    logic [31:0] r_tgt;
    for (int i = 0; i < 1024; i++) rom[i] = $urandom;
    rom[0]  = 32'h0022_1820;
    rom[1]  = 32'h2022_0064;
    rom[2]  = 32'h8C22_0004;
    rom[3]  = 32'hAC22_0008;
    rom[16] = 32'h2442_0001;
    rom[17] = 32'h0043_2020;

    // Boot and straight-line fetch
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0);
    // Stall with w2 in flight
    repeat (3) step(0, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0);
    // Jump to 0x40
    step(0, 0, 1, 32'h40);
    repeat (4) step(0, 0, 0, 0);
    // Redirect + stall while the skid holds a word
    step(0, 1, 0, 0);
    step(0, 1, 1, 32'h40);
    repeat (4) step(0, 0, 0, 0);
    // Reset mid-stream with skid full
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    repeat (6) step(0, 0, 0, 0);
    // Misaligned target
    step(0, 0, 1, 32'h42);
    repeat (4) step(0, 0, 0, 0);
`ifdef IF_ALIGN_CHECK_EN
    step(1, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0);
`endif

    for (int i = 0; i < 3000; i++) begin
      r_rst   = ($urandom_range(0, 199) == 0);
      r_stall = ($urandom_range(0, 3) == 0);
      r_redir = ($urandom_range(0, 24) == 0);
      r_tgt   = pick_target();
      step(r_rst, r_stall, r_redir, r_tgt);
    end
    repeat (4) step(0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
